seven_seg_scanner: RTL

Parametrised multiplexed seven-segment display driver, the successor to multi7seg. It drives NUM_DIGITS common-cathode/anode digits from a packed hex word and scans one digit per slot. It adds per-digit enable and decimal-point inputs, 16-level brightness PWM, tear-free frame snapshotting, and selectable output polarity. It sits at the devboard top level, fed from a core register or MMIO output port.

---
 rtl/seven_seg_scanner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Multiplexed seven-segment display driver. Scans NUM_DIGITS digits, one per
//   slot of 2**DIVIDE_LOG2 clock cycles, and dims them with a 16-level PWM.
//   All display inputs are copied into shadow registers once per frame so
//   that changes made mid-frame never tear the displayed value.
//
//   Optional feature: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank the hex
//   segments of leading-zero digits (digit 0 always shown, DP still applies).
//
// Ports
//   clock         system clock
//   reset         synchronous, active-high reset
//   data          packed hex nibbles, digit i = data[4i+3:4i]
//   decimalPoint  per-digit decimal point
//   digitEnable   per-digit enable; disabled digits are never driven
//   brightness    PWM level, 0 = 1/16 duty, 15 = full
//   segment       registered segments, bit 7 = DP, bits 6:0 = g..a
//   digit         registered one-hot digit select
//   frameStart    one-cycle pulse after the shadow registers load
module seven_seg_scanner #(
  parameter int NUM_DIGITS         = 4,
  parameter int DIVIDE_LOG2        = 16,
  parameter bit SEGMENT_ACTIVE_LOW = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   decimalPoint,
  input  logic [NUM_DIGITS-1:0]   digitEnable,
  input  logic [3:0]              brightness,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    frameStart
);

  localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  // XOR masks applied to the active-high internal values.
  localparam logic [7:0]            SEG_MASK = {8{SEGMENT_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_MASK = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

  logic [DIVIDE_LOG2-1:0]  div_count_reg;
  logic [IDX_W-1:0]        digit_index_reg;
  logic                    load_pending_reg;
  logic                    frame_start_reg;
  logic [4*NUM_DIGITS-1:0] shadow_data_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic [NUM_DIGITS-1:0]   shadow_en_reg;
  logic [3:0]              shadow_bright_reg;
  logic [7:0]              segment_reg;
  logic [NUM_DIGITS-1:0]   digit_reg;

  logic                    tick;
  logic                    frame_end;
  logic                    shadow_load;
  logic [3:0]              phase;
  logic                    pwm_on;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_blank;
  logic                    digit_active;
  logic [7:0]              segment_next;
  logic [NUM_DIGITS-1:0]   digit_next;

  function automatic logic [6:0] hex_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  assign tick        = &div_count_reg;
  assign frame_end   = tick && (digit_index_reg == LAST_IDX);
  // A pending load (set by reset) takes priority so the first frame after
  // reset shows current inputs instead of the cleared shadow.
  assign shadow_load = load_pending_reg || frame_end;
  assign phase       = div_count_reg[DIVIDE_LOG2-1 -: 4];
  assign pwm_on      = (phase <= shadow_bright_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
      assign digit_sel[gi] = (digit_index_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Digit i is a leading zero when it and every nibble above it are zero.
  assign blank[0] = 1'b0;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
      assign blank[gi] = ~|shadow_data_reg[4*NUM_DIGITS-1:4*gi];
    end
  endgenerate
`else
  assign blank = '0;
`endif

  always_comb begin
    cur_nibble = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel[i]) begin
        cur_nibble = shadow_data_reg[4*i +: 4];
      end
    end
  end

  assign cur_dp       = |(shadow_dp_reg & digit_sel);
  assign cur_en       = |(shadow_en_reg & digit_sel);
  assign cur_blank    = |(blank & digit_sel);
  assign digit_active = cur_en && pwm_on;

  always_comb begin
    segment_next = SEG_MASK;
    digit_next   = DIG_MASK;
    if (digit_active) begin
      segment_next = {cur_dp, (cur_blank ? 7'h00 : hex_decode(cur_nibble))} ^ SEG_MASK;
      digit_next   = digit_sel ^ DIG_MASK;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_count_reg     <= '0;
      digit_index_reg   <= '0;
      load_pending_reg  <= 1'b1;
      frame_start_reg   <= 1'b0;
      shadow_data_reg   <= '0;
      shadow_dp_reg     <= '0;
      shadow_en_reg     <= '0;
      shadow_bright_reg <= '0;
      segment_reg       <= SEG_MASK;
      digit_reg         <= DIG_MASK;
    end else begin
      div_count_reg   <= div_count_reg + DIVIDE_LOG2'(1);
      frame_start_reg <= shadow_load;
      segment_reg     <= segment_next;
      digit_reg       <= digit_next;
      if (tick) begin
        digit_index_reg <= frame_end ? '0 : digit_index_reg + IDX_W'(1);
      end
      if (shadow_load) begin
        load_pending_reg  <= 1'b0;
        shadow_data_reg   <= data;
        shadow_dp_reg     <= decimalPoint;
        shadow_en_reg     <= digitEnable;
        shadow_bright_reg <= brightness;
      end
    end
  end

  assign segment    = segment_reg;
  assign digit      = digit_reg;
  assign frameStart = frame_start_reg;

endmodule
